// File: rtl/traffic_light_controller_actuated.sv
// Vehicle-actuated N-way traffic light controller: round-robin green/yellow/all-red with demand skipping and green rest.
// Optional pedestrian walk phase is built when TLC_PED_WALK_EN is defined.
module traffic_light_controller_actuated #(
  parameter int unsigned N_WAYS       = 2,
  parameter int unsigned TIMER_W      = 8,
  parameter int unsigned PRESCALE     = 1,
  parameter int unsigned GREEN_MIN    = 4,
  parameter int unsigned GREEN_MAX    = 10,
  parameter int unsigned YELLOW_TICKS = 3,
  parameter int unsigned ALLRED_TICKS = 2,
  parameter int unsigned WALK_TICKS   = 5,
  localparam int unsigned AW = (N_WAYS > 1) ? $clog2(N_WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_WAYS-1:0] veh_req,
  input  logic              ped_req,
  output logic [N_WAYS-1:0] red,
  output logic [N_WAYS-1:0] yellow,
  output logic [N_WAYS-1:0] green,
  output logic              walk,
  output logic [AW-1:0]     active_way,
  output logic [1:0]        phase
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    S_ALLRED = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_WALK   = 2'd3
  } state_t;

  state_t              state, state_d;
  logic [TIMER_W-1:0]  timer, timer_d;
  logic [TIMER_W-1:0]  k_cnt, k_d;
  logic [PW-1:0]       pre_cnt, pre_d;
  logic [N_WAYS-1:0]   dem, dem_d;
  logic                first_pass, first_d;
  logic [AW-1:0]       active_d, tgt, nxt;
  logic                go_green, tick, other_dem;
  logic [N_WAYS-1:0]   way_onehot, onehot_d;
  logic [N_WAYS-1:0]   red_d, yellow_d, green_d;

`ifdef TLC_PED_WALK_EN
  logic ped_pend, ped_d;
`else
  logic unused_ped_req;
  localparam int unsigned unused_walk_ticks = WALK_TICKS;
  assign unused_ped_req = ped_req;
`endif

  assign tick       = (PRESCALE == 1) || (pre_cnt == PW'(PRESCALE - 1));
  assign way_onehot = N_WAYS'(1) << active_way;
  assign phase      = state;

  // Demand from any way other than the one being served.
  always_comb begin
    other_dem = 1'b0;
    for (int j = 0; j < int'(N_WAYS); j++) begin
      if (AW'(j) != active_way) other_dem = other_dem | dem[j];
    end
  end

  // Next way to serve: first latched demand after active_way, wrapping back to it last.
  always_comb begin
    logic          found;
    logic [AW-1:0] idx;
    nxt   = active_way;
    found = 1'b0;
    for (int off = 1; off <= int'(N_WAYS); off++) begin
      idx = AW'((int'(active_way) + off) % int'(N_WAYS));
      if (!found && dem[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

  // Next-state, timers and demand latches.
  always_comb begin
    state_d  = state;
    timer_d  = timer;
    k_d      = k_cnt;
    active_d = active_way;
    first_d  = first_pass;
    pre_d    = tick ? '0 : pre_cnt + PW'(1);
    dem_d    = dem | (veh_req & ~((state == S_GREEN) ? way_onehot : '0));
`ifdef TLC_PED_WALK_EN
    ped_d    = ped_pend | ped_req;
`endif
    go_green = 1'b0;
    tgt      = active_way;

    if (tick) begin
      case (state)
        S_ALLRED: begin
          if (timer == '0) begin
            if (first_pass) begin
              go_green = 1'b1;
              tgt      = '0;
            end
`ifdef TLC_PED_WALK_EN
            else if (ped_pend) begin
              state_d = S_WALK;
              timer_d = TIMER_W'(WALK_TICKS - 1);
              ped_d   = 1'b0;
            end
`endif
            else begin
              go_green = 1'b1;
              tgt      = nxt;
            end
          end else begin
            timer_d = timer - TIMER_W'(1);
          end
        end
        S_GREEN: begin
          k_d = (k_cnt < TIMER_W'(GREEN_MAX)) ? k_cnt + TIMER_W'(1) : k_cnt;
          if (other_dem && (((k_d >= TIMER_W'(GREEN_MIN)) && !veh_req[active_way]) ||
                            (k_d >= TIMER_W'(GREEN_MAX)))) begin
            state_d = S_YELLOW;
            timer_d = TIMER_W'(YELLOW_TICKS - 1);
          end
        end
        S_YELLOW: begin
          if (timer == '0) begin
            state_d = S_ALLRED;
            timer_d = TIMER_W'(ALLRED_TICKS - 1);
          end else begin
            timer_d = timer - TIMER_W'(1);
          end
        end
`ifdef TLC_PED_WALK_EN
        S_WALK: begin
          if (timer == '0) begin
            state_d = S_ALLRED;
            timer_d = TIMER_W'(ALLRED_TICKS - 1);
          end else begin
            timer_d = timer - TIMER_W'(1);
          end
        end
`endif
        default: begin
          state_d = S_ALLRED;
          timer_d = TIMER_W'(ALLRED_TICKS - 1);
        end
      endcase
    end

    // Green entry clears the served way's demand, overriding a same-cycle set.
    if (go_green) begin
      state_d     = S_GREEN;
      k_d         = '0;
      active_d    = tgt;
      first_d     = 1'b0;
      dem_d[tgt]  = 1'b0;
    end

    if (state_d != state) pre_d = '0;
  end

  // Lamp decode of the upcoming state so the lamp registers track the state register.
  always_comb begin
    onehot_d = N_WAYS'(1) << active_d;
    red_d    = '1;
    yellow_d = '0;
    green_d  = '0;
    case (state_d)
      S_GREEN: begin
        green_d = onehot_d;
        red_d   = ~onehot_d;
      end
      S_YELLOW: begin
        yellow_d = onehot_d;
        red_d    = ~onehot_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_ALLRED;
      timer      <= TIMER_W'(ALLRED_TICKS - 1);
      k_cnt      <= '0;
      pre_cnt    <= '0;
      dem        <= '0;
      first_pass <= 1'b1;
      active_way <= '0;
      red        <= '1;
      yellow     <= '0;
      green      <= '0;
    end else begin
      state      <= state_d;
      timer      <= timer_d;
      k_cnt      <= k_d;
      pre_cnt    <= pre_d;
      dem        <= dem_d;
      first_pass <= first_d;
      active_way <= active_d;
      red        <= red_d;
      yellow     <= yellow_d;
      green      <= green_d;
    end
  end

`ifdef TLC_PED_WALK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ped_pend <= 1'b0;
      walk     <= 1'b0;
    end else begin
      ped_pend <= ped_d;
      walk     <= (state_d == S_WALK);
    end
  end
`else
  assign walk = 1'b0;
`endif

endmodule
